// File: rtl/rv32_pkg.sv
// Shared opcodes, funct3 encodings and LSU state type for the RV32 memory stage.
package rv32_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  // Stores have no unsigned variants, so anything above SW is reserved.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return f3 > F3_W;
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32_load_align.sv
// Selects the addressed byte/half of a load response word and extends it to 32 bits.
module rv32_load_align
  import rv32_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0, half_sel};
      F3_W:    data = rdata;
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/rv32_lsu.sv
// Memory-stage load/store unit: issues one data-memory request per load/store,
// waits for the handshake and returns extended load data or an error pulse.
//
// state | meaning
// IDLE  | accept a new mem op; illegal/misaligned ops complete here without a request
// REQ   | dmem_req_valid high, request fields held until dmem_req_ready
// RESP  | load accepted, waiting for dmem_rsp_valid
module rv32_lsu
  import rv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] rs2_data_in,
  output logic        stall_out,
  output logic        wb_valid_out,
  output logic        wb_we_out,
  output logic [4:0]  wb_rd_out,
  output logic [31:0] wb_data_out,
  output logic        misalign_out,
  output logic        illegal_out,
  output logic        bus_err_out,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata
);

  localparam int         CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit         TMO_EN   = TIMEOUT_CYCLES > 0;
  localparam logic [CW-1:0] TMO_LOAD = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_t  state, state_nxt;
  logic [CW-1:0] tmo_cnt;
  logic        tmo_tc;

  logic [6:0]  opcode;
  logic [2:0]  f3_in;
  logic        is_store, mem_op, capture;
  logic        bad_f3, bad_align;

  logic        store_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic [1:0]  alo_q;

  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] load_data;

  logic        wb_fire, wb_we_n, mis_n, ill_n, berr_n;
  logic [4:0]  wb_rd_n;

  logic        unused_iw;
  assign unused_iw = ^iw_in[31:15];

  assign opcode    = iw_in[6:0];
  assign f3_in     = iw_in[14:12];
  assign is_store  = opcode == OP_STORE;
  assign mem_op    = ex_valid_in & ((opcode == OP_LOAD) | is_store);
  assign capture   = (state == IDLE) & mem_op;
  assign bad_f3    = f3_illegal(is_store, f3_in);
  assign bad_align = addr_misaligned(f3_in, addr_in[1:0]);

  assign stall_out      = capture | (state != IDLE);
  assign dmem_req_valid = state == REQ;
  assign tmo_tc         = TMO_EN && (state != IDLE) && (tmo_cnt == '0);

  always_comb begin
    be_n    = 4'b0000;
    wdata_n = 32'h0;
    if (is_store) begin
      case (f3_in)
        F3_B: begin
          be_n    = 4'b0001 << addr_in[1:0];
          wdata_n = {4{rs2_data_in[7:0]}};
        end
        F3_H: begin
          be_n    = addr_in[1] ? 4'b1100 : 4'b0011;
          wdata_n = {2{rs2_data_in[15:0]}};
        end
        default: begin
          be_n    = 4'b1111;
          wdata_n = rs2_data_in;
        end
      endcase
    end
  end

  rv32_load_align u_align (
    .rdata   (dmem_rsp_rdata),
    .addr_lo (alo_q),
    .funct3  (f3_q),
    .data    (load_data)
  );

  always_comb begin
    state_nxt = state;
    wb_fire   = 1'b0;
    wb_we_n   = 1'b0;
    mis_n     = 1'b0;
    ill_n     = 1'b0;
    berr_n    = 1'b0;
    wb_rd_n   = (state == IDLE) ? iw_in[11:7] : rd_q;
    case (state)
      IDLE: begin
        if (mem_op) begin
          if (bad_f3 || bad_align) begin
            wb_fire = 1'b1;
            ill_n   = bad_f3;
            mis_n   = bad_align & ~bad_f3;
          end else begin
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (dmem_req_ready) begin
          if (store_q) begin
            state_nxt = IDLE;
            wb_fire   = 1'b1;
          end else begin
            state_nxt = RESP;
          end
        end else if (tmo_tc) begin
          state_nxt = IDLE;
          wb_fire   = 1'b1;
          berr_n    = 1'b1;
        end
      end
      RESP: begin
        if (dmem_rsp_valid) begin
          state_nxt = IDLE;
          wb_fire   = 1'b1;
          wb_we_n   = 1'b1;
        end else if (tmo_tc) begin
          state_nxt = IDLE;
          wb_fire   = 1'b1;
          berr_n    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (capture && (state_nxt == REQ)) tmo_cnt <= TMO_LOAD;
      else if (state_nxt == IDLE)        tmo_cnt <= '0;
      else if (tmo_cnt != '0)            tmo_cnt <= tmo_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      store_q      <= 1'b0;
      f3_q         <= 3'b000;
      rd_q         <= 5'd0;
      alo_q        <= 2'b00;
      dmem_addr    <= 32'h0;
      dmem_we      <= 1'b0;
      dmem_be      <= 4'b0000;
      dmem_wdata   <= 32'h0;
      wb_valid_out <= 1'b0;
      wb_we_out    <= 1'b0;
      wb_rd_out    <= 5'd0;
      wb_data_out  <= 32'h0;
      misalign_out <= 1'b0;
      illegal_out  <= 1'b0;
      bus_err_out  <= 1'b0;
    end else begin
      if (capture) begin
        store_q    <= is_store;
        f3_q       <= f3_in;
        rd_q       <= iw_in[11:7];
        alo_q      <= addr_in[1:0];
        dmem_addr  <= {addr_in[31:2], 2'b00};
        dmem_we    <= is_store;
        dmem_be    <= be_n;
        dmem_wdata <= wdata_n;
      end
      wb_valid_out <= wb_fire;
      wb_we_out    <= wb_we_n;
      wb_rd_out    <= wb_fire ? wb_rd_n : 5'd0;
      wb_data_out  <= wb_we_n ? load_data : 32'h0;
      misalign_out <= mis_n;
      illegal_out  <= ill_n;
      bus_err_out  <= berr_n;
    end
  end

endmodule

// File: tb/tb_rv32_lsu.sv
// Self-checking bench for rv32_lsu: transaction-level expectations per op plus directed literals.
module tb_rv32_lsu;
  import rv32_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ex_valid_in, dmem_req_ready, dmem_rsp_valid;
  logic [31:0] iw_in, addr_in, rs2_data_in, dmem_rsp_rdata;

  logic        stall, wb_valid, wb_we, mis, ill, berr, req_valid, d_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, d_addr, d_wdata;
  logic [3:0]  d_be;

  logic        stall_t, wb_valid_t, wb_we_t, mis_t, ill_t, berr_t, req_valid_t, d_we_t;
  logic [4:0]  wb_rd_t;
  logic [31:0] wb_data_t, d_addr_t, d_wdata_t;
  logic [3:0]  d_be_t;

  rv32_lsu #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .ex_valid_in(ex_valid_in), .iw_in(iw_in), .addr_in(addr_in),
    .rs2_data_in(rs2_data_in), .stall_out(stall), .wb_valid_out(wb_valid), .wb_we_out(wb_we),
    .wb_rd_out(wb_rd), .wb_data_out(wb_data), .misalign_out(mis), .illegal_out(ill),
    .bus_err_out(berr), .dmem_req_valid(req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(d_addr), .dmem_we(d_we), .dmem_be(d_be), .dmem_wdata(d_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata));

  rv32_lsu #(.TIMEOUT_CYCLES(4)) dut_t (
    .clk(clk), .reset(reset), .ex_valid_in(ex_valid_in), .iw_in(iw_in), .addr_in(addr_in),
    .rs2_data_in(rs2_data_in), .stall_out(stall_t), .wb_valid_out(wb_valid_t), .wb_we_out(wb_we_t),
    .wb_rd_out(wb_rd_t), .wb_data_out(wb_data_t), .misalign_out(mis_t), .illegal_out(ill_t),
    .bus_err_out(berr_t), .dmem_req_valid(req_valid_t), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(d_addr_t), .dmem_we(d_we_t), .dmem_be(d_be_t), .dmem_wdata(d_wdata_t),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic m_legal(input logic st, input logic [2:0] f3);
    if (st) return f3 <= 3'd2;
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic logic m_misal(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = 1 << f3[1:0];
    return (int'(a[3:0]) % sz) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic st, input logic [2:0] f3, input logic [31:0] a);
    if (!st) return 4'b0000;
    case (f3[1:0])
      2'd0:    return 4'b0001 << a[1:0];
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'd0:    return 32'(d[7:0]) * 32'h0101_0101;
      2'd1:    return 32'(d[15:0]) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] s;
    int v;
    s = w >> (8 * a[1:0]);
    case (f3)
      3'd0: begin v = int'(s[7:0]);  if (v > 127)   v = v - 256;   return 32'(v); end
      3'd1: begin v = int'(s[15:0]); if (v > 32767) v = v - 65536; return 32'(v); end
      3'd4: return s & 32'hFF;
      3'd5: return s & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  logic        m_store, m_ill, m_mis, m_legal_op;
  logic [2:0]  m_f3;
  logic [4:0]  m_rd;
  logic [31:0] m_a, m_rs2, m_rdata;
  logic        chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_req = 1'b0, exp_wb = 1'b0, prev_wb = 1'b0;

  logic [31:0] last_req_addr, last_req_wdata, last_wb_data;
  logic [3:0]  last_req_be;
  logic        last_req_we, last_wb_we, last_mis, last_ill;

  always @(negedge clk) begin
    if (reset) begin
      prev_wb = 1'b0;
    end else if (chk_en) begin
      chk("stall", stall, exp_stall);
      chk("req_valid", req_valid, exp_req);
      chk("wb_valid", wb_valid, exp_wb);
      if (req_valid) begin
        chk("dmem_addr", d_addr, {m_a[31:2], 2'b00});
        chk("dmem_we", d_we, m_store);
        chk("dmem_be", d_be, m_be(m_store, m_f3, m_a));
        if (m_store) chk("dmem_wdata", d_wdata, m_wdata(m_f3, m_rs2));
        last_req_addr = d_addr; last_req_be = d_be; last_req_we = d_we; last_req_wdata = d_wdata;
      end
      if (wb_valid) begin
        chk("wb_we", wb_we, m_legal_op & ~m_store);
        chk("wb_rd", wb_rd, m_rd);
        chk("wb_data", wb_data, (m_legal_op & ~m_store) ? m_load(m_rdata, m_a, m_f3) : 32'h0);
        chk("misalign", mis, m_mis);
        chk("illegal", ill, m_ill);
        chk("bus_err", berr, 1'b0);
        chk("wb_gap", prev_wb, 1'b0);
        last_wb_data = wb_data; last_wb_we = wb_we; last_mis = mis; last_ill = ill;
      end else begin
        chk("idle_flags", {wb_we, mis, ill, berr}, 0);
      end
      prev_wb = wb_valid;
    end
  end

  // One complete op: capture at cycle 0, request held rdly extra cycles, response after sdly extra cycles.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] d2, input logic [31:0] rdata, input int rdly, input int sdly);
    int idx;
    m_store = st; m_f3 = f3; m_rd = rd; m_a = a; m_rs2 = d2; m_rdata = rdata;
    m_legal_op = m_legal(st, f3);
    m_ill = ~m_legal_op;
    m_mis = m_legal_op & m_misal(f3, a);
    if (m_ill || m_mis) m_legal_op = 1'b0;
    if (m_ill || m_mis) idx = 1;
    else idx = 1 + (rdly + 1) + (st ? 0 : sdly + 1);
    for (int c = 0; c <= idx + 1; c++) begin
      if (c == 0) begin
        ex_valid_in = 1'b1; iw_in = {17'h0, f3, rd, st ? OP_STORE : OP_LOAD};
        addr_in = a; rs2_data_in = d2;
      end else if (c < idx) begin
        ex_valid_in = 1'b1; iw_in = {17'h0, F3_W, 5'd31, OP_STORE};
        addr_in = 32'hDEAD_0000; rs2_data_in = 32'hFFFF_FFFF;
      end else begin
        ex_valid_in = 1'b1; iw_in = 32'h0000_0013;
        addr_in = 32'h0; rs2_data_in = 32'h0;
      end
      dmem_req_ready = m_legal_op && (c == 1 + rdly);
      dmem_rsp_valid = (m_legal_op && !st && c == 2 + rdly + sdly) || (c >= 1 && c <= rdly);
      dmem_rsp_rdata = (m_legal_op && !st && c == 2 + rdly + sdly) ? rdata : 32'hDEAD_BEEF;
      exp_stall = c < idx;
      exp_req   = m_legal_op && c >= 1 && c <= 1 + rdly;
      exp_wb    = c == idx;
      @(negedge clk);
      @(posedge clk); #1;
    end
    ex_valid_in = 1'b0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_wb = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ex_valid_in = 1'b0; iw_in = 32'h0; addr_in = 32'h0; rs2_data_in = 32'h0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 32'(|{stall, wb_valid, wb_we, wb_rd, wb_data, mis, ill, berr, req_valid,
                            d_addr, d_we, d_be, d_wdata}), 0);
    chk("reset_outs_t", 32'(|{stall_t, wb_valid_t, req_valid_t, d_addr_t, d_be_t, wb_data_t}), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;

    run_op(1'b0, F3_B, 5'd5, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 0, 0);
    chk("lb_addr", last_req_addr, 32'h0000_0100);
    chk("lb_be_we", {last_req_be, last_req_we}, 5'b0000_0);
    chk("lb_data", last_wb_data, 32'hFFFF_FF80);
    chk("lb_we", last_wb_we, 1'b1);

    run_op(1'b1, F3_H, 5'd6, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 0, 0);
    chk("sh_be", last_req_be, 4'b1100);
    chk("sh_wdata", last_req_wdata, 32'hABCD_ABCD);
    chk("sh_wb_we", last_wb_we, 1'b0);

    run_op(1'b0, F3_W, 5'd7, 32'h0000_0101, 32'h0, 32'h0, 0, 0);
    chk("lw_misalign", last_mis, 1'b1);

    run_op(1'b0, F3_HU, 5'd8, 32'h0000_0002, 32'h0, 32'hF00D_8001, 3, 0);
    chk("lhu_data", last_wb_data, 32'h0000_F00D);

    run_op(1'b1, F3_B, 5'd9, 32'h0000_0201, 32'h0000_0055, 32'h0, 0, 0);
    chk("sb_be", last_req_be, 4'b0010);
    chk("sb_wdata", last_req_wdata, 32'h5555_5555);

    run_op(1'b1, F3_W, 5'd10, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 2, 0);
    chk("sw_be", last_req_be, 4'b1111);

    run_op(1'b0, F3_H, 5'd11, 32'h0000_0102, 32'h0, 32'h8001_1234, 0, 2);
    chk("lh_data", last_wb_data, 32'hFFFF_8001);

    run_op(1'b0, F3_BU, 5'd15, 32'h0000_0102, 32'h0, 32'h12FE_3456, 1, 1);
    chk("lbu_data", last_wb_data, 32'h0000_00FE);

    run_op(1'b0, F3_W, 5'd16, 32'h0000_0400, 32'h0, 32'h89AB_CDEF, 0, 0);
    chk("lw_data", last_wb_data, 32'h89AB_CDEF);

    run_op(1'b0, 3'b011, 5'd12, 32'h0000_0100, 32'h0, 32'h0, 0, 0);
    chk("ld_illegal", last_ill, 1'b1);
    run_op(1'b1, 3'b011, 5'd13, 32'h0000_0100, 32'h0, 32'h0, 0, 0);
    chk("st_illegal", last_ill, 1'b1);
    run_op(1'b1, F3_H, 5'd14, 32'h0000_0201, 32'h0, 32'h0, 0, 0);
    chk("sh_misalign", last_mis, 1'b1);

    // Timeout on the TIMEOUT_CYCLES=4 instance: load accepted, response never arrives.
    chk_en = 1'b0;
    for (int c = 0; c < 11; c++) begin
      ex_valid_in    = (c == 0);
      iw_in          = {17'h0, F3_W, 5'd3, OP_LOAD};
      addr_in        = 32'h0000_0010;
      dmem_req_ready = (c == 1);
      dmem_rsp_valid = (c == 7);
      dmem_rsp_rdata = 32'h0000_1234;
      @(negedge clk);
      chk("tmo_stall", stall_t, c < 5);
      chk("tmo_wb_valid", wb_valid_t, c == 5);
      chk("tmo_bus_err", berr_t, c == 5);
      if (c == 5) chk("tmo_wb_we", {wb_we_t, mis_t, ill_t}, 0);
      if (c >= 5) chk("tmo_req_idle", req_valid_t, 1'b0);
      @(posedge clk); #1;
    end
    ex_valid_in = 1'b0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    do_reset();

    // Reset while a load sits in RESP.
    ex_valid_in = 1'b1; iw_in = {17'h0, F3_W, 5'd4, OP_LOAD}; addr_in = 32'h0000_0020;
    @(posedge clk); #1;
    ex_valid_in = 1'b0; dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    #2;
    chk("resp_busy", {stall, req_valid}, 2'b10);
    reset = 1'b1;
    #1;
    chk("mid_reset_outs", 32'(|{stall, wb_valid, wb_we, wb_rd, wb_data, mis, ill, berr, req_valid,
                                d_addr, d_we, d_be, d_wdata}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    prev_wb = 1'b0;
    chk_en = 1'b1;
    run_op(1'b0, F3_BU, 5'd1, 32'h0000_0001, 32'h0, 32'h0000_FF00, 0, 0);
    chk("post_rst_lbu", last_wb_data, 32'h0000_00FF);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
